p_mul_seq: RTL and testbench

Sequential packed unsigned multiplier for the xcrypto datapath. It treats two 32-bit operands as packed lanes of 32, 16, 8, 4 or 2 bits and multiplies corresponding lanes using shift-and-add, one partial product per cycle. Each lane uses a lane-segmented add, with no carry propagation across lane boundaries. Each lane's full 2W-bit product is returned split into a low-half word and a high-half word. It sits beside the combinational packed add/sub unit in the instruction execute stage and is driven by the same one-hot pack-width encoding.

---
 rtl/p_mul_seq.sv | 196 +++++++++++++++++++
 tb/tb_p_mul_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/p_mul_seq.sv
// Sequential packed unsigned multiplier.
// Treats lhs/rhs as packed lanes of 32, 16, 8, 4 or 2 bits, selected by a
// one-hot pack width. Each lane does one shift-and-add step per cycle.
// Carries never cross a lane boundary. When the operation completes, each
// lane's 2W-bit product is presented as a low half (result_lo) and a high
// half (result_hi).
//
// state | meaning
// IDLE  | waiting for a request; loads operands or short-cuts a bad pw
// BUSY  | one partial product per cycle in every lane, W cycles in total
// DONE  | ready pulse; acc/mlr hold the finished high/low product halves

module p_mul_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [4:0]  pw,
  output logic        ready,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mlr_q, mlr_d;
  logic [5:0]  cnt_q, cnt_d;

  // Lane geometry derived from the pack width.
  logic [31:0] lane_lsb;
  logic [31:0] lane_msb;
  logic [5:0]  cnt_last;
  logic        pw_onehot;

  // One shift-and-add step for all lanes.
  logic [31:0] sum;
  logic [31:0] cout;
  logic [31:0] lane_s0;
  logic [31:0] acc_step;
  logic [31:0] mlr_step;
  logic [4:0]  lsb_idx;
  logic        carry;
  logic        s0;
  logic        addend;

  // Lane boundary masks and final iteration count for the selected width.
  always_comb begin
    lane_lsb  = 32'h0000_0001;
    lane_msb  = 32'h8000_0000;
    cnt_last  = 6'd31;
    pw_onehot = 1'b1;
    case (pw)
      5'b00001: begin
        lane_lsb = 32'h0000_0001;
        lane_msb = 32'h8000_0000;
        cnt_last = 6'd31;
      end
      5'b00010: begin
        lane_lsb = 32'h0001_0001;
        lane_msb = 32'h8000_8000;
        cnt_last = 6'd15;
      end
      5'b00100: begin
        lane_lsb = 32'h0101_0101;
        lane_msb = 32'h8080_8080;
        cnt_last = 6'd7;
      end
      5'b01000: begin
        lane_lsb = 32'h1111_1111;
        lane_msb = 32'h8888_8888;
        cnt_last = 6'd3;
      end
      5'b10000: begin
        lane_lsb = 32'h5555_5555;
        lane_msb = 32'hAAAA_AAAA;
        cnt_last = 6'd1;
      end
      default: begin
        pw_onehot = 1'b0;
      end
    endcase
  end

  // Lane-segmented add of acc and the gated multiplicand, then a one-bit
  // right shift of {carry, sum, mlr} within each lane.
  always_comb begin
    sum      = '0;
    cout     = '0;
    lane_s0  = '0;
    acc_step = '0;
    mlr_step = '0;
    lsb_idx  = '0;
    carry    = 1'b0;
    s0       = 1'b0;
    addend   = 1'b0;

    for (int i = 0; i < 32; i++) begin
      if (lane_lsb[i]) begin
        carry   = 1'b0;
        lsb_idx = i[4:0];
      end
      addend  = lhs[i] & mlr_q[lsb_idx];
      sum[i]  = acc_q[i] ^ addend ^ carry;
      carry   = (acc_q[i] & addend) | (acc_q[i] & carry) | (addend & carry);
      cout[i] = carry;
      if (lane_lsb[i]) begin
        s0 = sum[i];
      end
      lane_s0[i] = s0;
    end

    // Bit 31 is the top of a lane for every width.
    for (int i = 0; i < 31; i++) begin
      if (lane_msb[i]) begin
        acc_step[i] = cout[i];
        mlr_step[i] = lane_s0[i];
      end else begin
        acc_step[i] = sum[i+1];
        mlr_step[i] = mlr_q[i+1];
      end
    end
    acc_step[31] = cout[31];
    mlr_step[31] = lane_s0[31];
  end

  // Next-state and datapath register selection.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mlr_d   = mlr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid && !flush) begin
          acc_d = '0;
          cnt_d = '0;
          if (pw_onehot) begin
            mlr_d   = rhs;
            state_d = BUSY;
          end else begin
            mlr_d   = '0;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (flush || !valid) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          mlr_d = mlr_step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == cnt_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mlr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mlr_q   <= mlr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come straight from registers. The product halves are only
  // meaningful while ready is high.
  assign ready     = (state_q == DONE);
  assign result_hi = acc_q;
  assign result_lo = mlr_q;

endmodule

// File: tb/tb_p_mul_seq.sv
// Directed test of p_mul_seq. Inputs are driven 1 ns after the rising edge
// and outputs are sampled on the falling edge. Cycle 0 is the cycle in
// which a request is first presented.

module tb_p_mul_seq;

  logic        g_clk;
  logic        g_resetn;
  logic        valid;
  logic        flush;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [4:0]  pw;
  logic        ready;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int n_cmp;
  int n_err;

  p_mul_seq u_dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .valid     (valid),
    .flush     (flush),
    .lhs       (lhs),
    .rhs       (rhs),
    .pw        (pw),
    .ready     (ready),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request in the next cycle (cycle 0 of that operation).
  task automatic start(input logic [4:0] p, input logic [31:0] a, input logic [31:0] b);
    @(posedge g_clk);
    #1;
    valid = 1'b1;
    flush = 1'b0;
    pw    = p;
    lhs   = a;
    rhs   = b;
  endtask

  // Wait for ready, counting cycles from cycle 0; a timeout shows up as a
  // latency mismatch.
  task automatic wait_ready(input string tag, input int exp_lat,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    @(negedge g_clk);
    while (!ready && n < 80) begin
      @(negedge g_clk);
      n++;
    end
    chk($sformatf("%s_lat", tag), n, exp_lat);
    chk($sformatf("%s_hi", tag), result_hi, exp_hi);
    chk($sformatf("%s_lo", tag), result_lo, exp_lo);
  endtask

  // Drop the request in the cycle after ready and confirm ready was a pulse.
  task automatic go_idle(input string tag);
    @(posedge g_clk);
    #1;
    valid = 1'b0;
    flush = 1'b0;
    @(negedge g_clk);
    chk($sformatf("%s_pulse", tag), {31'd0, ready}, 32'd0);
  endtask

  initial begin
    int seen;
    n_cmp    = 0;
    n_err    = 0;
    g_resetn = 1'b0;
    valid    = 1'b0;
    flush    = 1'b0;
    pw       = 5'b00001;
    lhs      = '0;
    rhs      = '0;

    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_lo", result_lo, 32'd0);
    chk("rst_hi", result_hi, 32'd0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;

    // 32-bit lanes: 0xFFFFFFFF squared.
    start(5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready("w32", 33, 32'hFFFF_FFFE, 32'h0000_0001);
    go_idle("w32");

    // 16-bit lanes, no carry leak between lanes.
    start(5'b00010, 32'h0003_FFFF, 32'h0005_FFFF);
    wait_ready("w16", 17, 32'h0000_FFFE, 32'h000F_0001);
    go_idle("w16");

    // 8-bit lanes.
    start(5'b00100, 32'h10FF_0280, 32'h10FF_0302);
    wait_ready("w8", 9, 32'h01FE_0001, 32'h0001_0600);
    go_idle("w8");

    // 2-bit lanes, then a back-to-back request with zero operands.
    start(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready("w2", 3, 32'hAAAA_AAAA, 32'h5555_5555);
    start(5'b10000, 32'h0000_0000, 32'h0000_0000);
    wait_ready("w2b2b", 3, 32'h0000_0000, 32'h0000_0000);
    go_idle("w2b2b");

    // Flush at cycle 10 of a 32-bit op, then a 4-bit op starting at cycle 12.
    start(5'b00001, 32'h1234_5678, 32'h9ABC_DEF0);
    seen = 0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge g_clk);
      #1;
      if (c == 10) flush = 1'b1;
      if (c == 11) begin
        flush = 1'b0;
        valid = 1'b0;
      end
      @(negedge g_clk);
      if (ready) seen++;
    end
    chk("flush_noready", seen, 0);
    start(5'b01000, 32'h0000_000F, 32'h0000_000F);
    wait_ready("w4", 5, 32'h0000_000E, 32'h0000_0001);
    go_idle("w4");

    // flush wins over valid in IDLE.
    @(posedge g_clk);
    #1;
    valid = 1'b1;
    flush = 1'b1;
    pw    = 5'b10000;
    seen  = 0;
    repeat (5) begin
      @(negedge g_clk);
      if (ready) seen++;
      @(posedge g_clk);
    end
    #1;
    valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush", seen, 0);

    // Asynchronous reset at cycle 5 of a 32-bit op.
    start(5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge g_clk);
    #1;
    g_resetn = 1'b0;
    valid    = 1'b0;
    @(negedge g_clk);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_lo", result_lo, 32'd0);
    chk("mid_rst_hi", result_hi, 32'd0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge g_clk);
      if (ready) seen++;
    end
    chk("post_rst_noready", seen, 0);

    // Bad pack widths short-cut to a zero result one cycle later.
    start(5'b00000, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    wait_ready("pw0", 1, 32'd0, 32'd0);
    go_idle("pw0");
    start(5'b00011, 32'h0000_00FF, 32'h0000_00FF);
    wait_ready("pwmulti", 1, 32'd0, 32'd0);
    go_idle("pwmulti");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
